// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests into a per-stage
// stall vector, drives the global flush, and times multi-cycle EX operations.
module pipeline_ctrl #(
  parameter int unsigned CNT_WIDTH  = 6,
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_stall_request,
  input  logic                  ex_stall_request,
  input  logic                  mem_stall_request,
  input  logic                  flush_request,
  input  logic                  mc_start,
  input  logic [CNT_WIDTH-1:0]  mc_cycles,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [5:0]            stall,
  output logic                  flush,
  output logic [PERF_WIDTH-1:0] stall_cycle_count
);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_mc_busy;
  logic                  r_mc_done;
  logic [PERF_WIDTH-1:0] r_perf;

  logic [CNT_WIDTH-1:0]  w_load;
  logic                  w_ex_eff;
  logic [5:0]            w_stall;

  // A zero length request runs as a single busy cycle.
  assign w_load = (mc_cycles == '0) ? '0 : mc_cycles - CNT_WIDTH'(1);

  // Multi-cycle sequencer; flush always wins and suppresses the done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_mc_busy <= 1'b0;
      r_mc_done <= 1'b0;
    end else begin
      r_mc_done <= 1'b0;
      if (flush_request) begin
        r_state   <= S_IDLE;
        r_count   <= '0;
        r_mc_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (mc_start) begin
              r_state   <= S_BUSY;
              r_count   <= w_load;
              r_mc_busy <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
            end
          end
          S_BUSY: begin
            if (r_count != '0) begin
              r_count <= r_count - CNT_WIDTH'(1);
            end else begin
              r_state   <= S_DONE;
              r_mc_busy <= 1'b0;
              r_mc_done <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_mc_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // EX holds while the unit runs and in the cycle a new operation is issued.
  assign w_ex_eff = ex_stall_request | (r_state == S_BUSY) |
                    (mc_start & (r_state != S_BUSY));

  always_comb begin
    w_stall = STALL_NONE;
    if (!reset || flush_request) begin
      w_stall = STALL_NONE;
    end else if (mem_stall_request) begin
      w_stall = STALL_MEM;
    end else if (w_ex_eff) begin
      w_stall = STALL_EX;
    end else if (id_stall_request) begin
      w_stall = STALL_ID;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf <= '0;
    end else if ((w_stall != STALL_NONE) && (r_perf != '1)) begin
      r_perf <= r_perf + PERF_WIDTH'(1);
    end
  end

  assign stall             = w_stall;
  assign flush             = reset & flush_request;
  assign mc_busy           = r_mc_busy;
  assign mc_done           = r_mc_done;
  assign stall_cycle_count = r_perf;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline sequencing controller for the five-stage MIPS core.
- Merges stall requests from ID, EX and MEM into one per-stage stall vector, and issues flush to every inter-stage buffer (if/id through mem/wb).
- Sequences multi-cycle EX operations (DIV/MADD writing HI/LO): holds the pipe for a programmed number of cycles, then pulses completion.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_WIDTH, 6, width of the multi-cycle length field (max 63 busy cycles).
- PERF_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- id_stall_request  in  1  ID needs a hold (load-use hazard).
- ex_stall_request  in  1  EX needs a hold (single-cycle hazard).
- mem_stall_request  in  1  MEM waiting on data memory.
- flush_request  in  1  exception/eret: squash all in-flight instructions.
- mc_start  in  1  EX begins a multi-cycle operation this cycle.
- mc_cycles  in  CNT_WIDTH  busy length N for that operation.
- mc_busy  out  1  multi-cycle unit occupied (registered).
- mc_done  out  1  one-cycle completion pulse; HI/LO result valid (registered).
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb (combinational).
- flush  out  1  flush to all buffers (combinational).
- stall_cycle_count  out  PERF_WIDTH  cycles with stall!=0, saturating.

Behaviour:
- Reset (reset==0, async): state IDLE, count 0, mc_busy 0, mc_done 0, stall_cycle_count 0. While reset is low, stall=0 and flush=0 regardless of inputs.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: mc_start & ~flush_request -> BUSY, count <= max(N,1)-1. mc_cycles==0 is treated as N=1.
  - BUSY: mc_busy=1. If count!=0, count <= count-1. If count==0, go to DONE. mc_start is ignored.
  - DONE: mc_done=1 for exactly one cycle. mc_start -> BUSY (same rules as IDLE); otherwise -> IDLE.
  - flush_request in any state -> IDLE next edge; count cleared; no mc_done is generated. flush overrides mc_start in the same cycle.
- Timing: mc_start sampled at edge T gives mc_busy high for cycles T+1..T+N and mc_done high at cycle T+N+1.
- Effective EX stall: ex_eff = ex_stall_request | (state==BUSY) | (mc_start & state!=BUSY).
- stall priority, highest first:
  - flush_request: stall = 6'b000000.
  - mem_stall_request: stall = 6'b011111.
  - ex_eff: stall = 6'b001111.
  - id_stall_request: stall = 6'b000111.
  - otherwise: 6'b000000.
- flush = flush_request (same cycle; buffers clear at the next edge).
- Perf counter: increments each cycle in which stall!=0; holds at all-ones (no wrap). Flush cycles do not count.
- Simultaneous mem stall and BUSY: MEM dominates the vector; the multi-cycle count still advances (the divider runs independently).
- mc_done coinciding with mem_stall_request: pulse still lasts one cycle. EX must capture the result on mc_done regardless of the stall.

Test Plan:
- Reset low mid-BUSY with mc_busy=1 and count=5 -> all outputs 0 immediately (async); after release, state IDLE and no mc_done.
- mc_start with mc_cycles=4 at edge T, no other requests -> stall=6'b001111 in cycles T..T+4, mc_busy cycles T+1..T+4, mc_done only at T+5, stall=0 at T+5, stall_cycle_count=5.
- mc_cycles=0 -> behaves as N=1: one busy cycle, mc_done at T+2.
- flush_request at second BUSY cycle of N=8 -> stall=0 and flush=1 that cycle; next cycle mc_busy=0; mc_done never asserted.
- id, ex and mem requests all high for 1 cycle -> stall=6'b011111. id only -> 6'b000111. id+flush -> 6'b000000, flush=1.
- Back-to-back: mc_start held high during DONE -> mc_done pulse, then BUSY again next cycle with no IDLE gap. mc_start during BUSY -> ignored; total busy length unchanged.
- Force stall_cycle_count to all-ones minus 1, hold stall 3 cycles -> counter reaches all-ones and stays there.
